// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the pipelined data RAM.
// Clear FSM states, read latency bounds and the byte-merge function.
package data_ram_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;
  localparam int MERGE_W      = 256;

  // Widest supported word; callers zero-extend and truncate around it.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/8-1:0] mask
  );
    logic [MERGE_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MERGE_W/8; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram_clear_fsm.sv
// Clear engine: walks every word once, emitting a zero-write per cycle.
// Busy is the registered CLEAR state, so it rises the cycle after the request.
module data_ram_clear_fsm
  import data_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy     = (state_q == ST_CLEAR);
  assign o_clr_we   = o_busy;
  assign o_clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/data_ram_pipelined.sv
// 1W/1R data RAM with byte masks, write-first bypass, 1-2 cycle read
// latency, hardware clear engine and out-of-range address detection.
module data_ram_pipelined
  import data_ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                ctrl_write,
  input  logic [ADDR_W-1:0]   i_addr_write,
  input  logic [DATA_W-1:0]   i_data_write,
  input  logic [DATA_W/8-1:0] i_wmask,
  input  logic                ctrl_read,
  input  logic [ADDR_W-1:0]   i_addr_read,
  output logic [DATA_W-1:0]   o_data_read,
  output logic                o_read_valid,
  input  logic                ctrl_clear,
  output logic                o_busy,
  output logic                o_addr_err
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("DATA_W must be a multiple of 8");
  end
  if (DATA_W > MERGE_W) begin : g_big_dw
    $error("DATA_W exceeds MERGE_W");
  end
  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("READ_LAT must be 1 or 2");
  end
  if (DEPTH < 2 || DEPTH > 2**ADDR_W) begin : g_bad_depth
    $error("DEPTH out of range for ADDR_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  data_ram_clear_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (ctrl_clear),
    .o_busy     (busy),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr)
  );

  logic              idle;
  logic              wr_oob, rd_oob;
  logic              user_we, rd_req;
  logic [DATA_W-1:0] merged_write;
  logic [DATA_W-1:0] rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign idle   = ~busy;
  assign wr_oob = {1'b0, i_addr_write} >= DEPTH_V;
  assign rd_oob = {1'b0, i_addr_read} >= DEPTH_V;

  always_comb begin
    merged_write = DATA_W'(byte_merge(
      MERGE_W'(mem_q[i_addr_write]),
      MERGE_W'(i_data_write),
      (MERGE_W/8)'(i_wmask)));
    user_we = idle & ctrl_write & ~wr_oob & (|i_wmask);
    rd_req  = idle & ctrl_read;
    rd_word = '0;
    if (!rd_oob) begin
      // Write-first: a same-cycle write to the read address is forwarded.
      if (user_we && (i_addr_write == i_addr_read)) rd_word = merged_write;
      else rd_word = mem_q[i_addr_read];
    end
    mem_we    = clr_we | user_we;
    mem_waddr = clr_we ? clr_addr : i_addr_write;
    mem_wdata = clr_we ? '0 : merged_write;
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic              err_q, err_d;

  always_comb begin
    rv1_d = rd_req;
    rd1_d = rd_req ? rd_word : '0;
    err_d = idle & ((ctrl_write & wr_oob) | (ctrl_read & rd_oob));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rv1_q <= 1'b0;
      rd1_q <= '0;
      err_q <= 1'b0;
    end else begin
      rv1_q <= rv1_d;
      rd1_q <= rd1_d;
      err_q <= err_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              rv2_q;
    logic [DATA_W-1:0] rd2_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rv2_q <= 1'b0;
        rd2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        rd2_q <= rd1_q;
      end
    end
    assign o_read_valid = rv2_q;
    assign o_data_read  = rd2_q;
  end else begin : g_lat1
    assign o_read_valid = rv1_q;
    assign o_data_read  = rd1_q;
  end

  assign o_busy     = busy;
  assign o_addr_err = err_q;

endmodule

// File: tb/tb_data_ram_pipelined.sv
// Bench: two RAM instances (256/lat1, 200/lat2) on shared stimulus,
// compared every cycle against a behavioural memory model.
module tb_data_ram_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cw = 1'b0, cr = 1'b0, cc = 1'b0;
  logic [7:0]  aw = '0, ar = '0;
  logic [15:0] dw = '0;
  logic [1:0]  wm = '0;

  logic [15:0] a_data, b_data;
  logic        a_v, b_v, a_busy, b_busy, a_err, b_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_ram_pipelined #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .READ_LAT(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .ctrl_write(cw), .i_addr_write(aw), .i_data_write(dw), .i_wmask(wm),
    .ctrl_read(cr), .i_addr_read(ar),
    .o_data_read(a_data), .o_read_valid(a_v),
    .ctrl_clear(cc), .o_busy(a_busy), .o_addr_err(a_err));

  data_ram_pipelined #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .READ_LAT(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .ctrl_write(cw), .i_addr_write(aw), .i_data_write(dw), .i_wmask(wm),
    .ctrl_read(cr), .i_addr_read(ar),
    .o_data_read(b_data), .o_read_valid(b_v),
    .ctrl_clear(cc), .o_busy(b_busy), .o_addr_err(b_err));

  // Model state per instance.
  logic [15:0] mm [2][256];
  int          bc [2];
  int          dep [2] = '{256, 200};
  int          lat [2] = '{1, 2};
  logic        ex_err [2];
  logic [16:0] dl [2][2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      bc[k] = 0;
      ex_err[k] = 1'b0;
      dl[k][0] = '0;
      dl[k][1] = '0;
    end
  endtask

  task automatic model_step(input int k);
    logic [15:0] rdat;
    logic        rv;
    logic        e;
    rdat = '0;
    rv = 1'b0;
    e = 1'b0;
    if (bc[k] > 0) begin
      mm[k][dep[k] - bc[k]] = '0;
      bc[k]--;
    end else begin
      if (cw && int'(aw) >= dep[k]) e = 1'b1;
      if (cr && int'(ar) >= dep[k]) e = 1'b1;
      if (cw && int'(aw) < dep[k]) begin
        for (int b = 0; b < 2; b++)
          if (wm[b]) mm[k][aw][8*b +: 8] = dw[8*b +: 8];
      end
      if (cr) begin
        rv = 1'b1;
        rdat = (int'(ar) < dep[k]) ? mm[k][ar] : 16'h0;
      end
      if (cc) bc[k] = dep[k];
    end
    ex_err[k] = e;
    dl[k][1] = dl[k][0];
    dl[k][0] = {rv, rdat};
  endtask

  always @(posedge clk) begin
    logic [16:0] ex;
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end else begin
      model_reset();
    end
    #1;
    ex = dl[0][lat[0]-1];
    chk("mon_a_valid", 32'(a_v), 32'(ex[16]));
    chk("mon_a_data", 32'(a_data), 32'(ex[15:0]));
    chk("mon_a_busy", 32'(a_busy), 32'(bc[0] > 0));
    chk("mon_a_err", 32'(a_err), 32'(ex_err[0]));
    ex = dl[1][lat[1]-1];
    chk("mon_b_valid", 32'(b_v), 32'(ex[16]));
    chk("mon_b_data", 32'(b_data), 32'(ex[15:0]));
    chk("mon_b_busy", 32'(b_busy), 32'(bc[1] > 0));
    chk("mon_b_err", 32'(b_err), 32'(ex_err[1]));
  end

  task automatic step(input logic w, input logic [7:0] wa,
                      input logic [15:0] wd, input logic [1:0] m,
                      input logic r, input logic [7:0] ra,
                      input logic c);
    cw = w; aw = wa; dw = wd; wm = m;
    cr = r; ar = ra; cc = c;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b0, 8'h0, 1'b0);
  endtask

  initial begin
    int na, nb, nv;
    model_reset();
    @(negedge clk);
    chk("rst_a_data", 32'(a_data), 32'h0);
    chk("rst_a_valid", 32'(a_v), 32'h0);
    chk("rst_a_busy", 32'(a_busy), 32'h0);
    chk("rst_b_err", 32'(b_err), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clear: busy duration, ignored requests, zeroed contents.
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b0, 8'h0, 1'b1);
    na = 0; nb = 0; nv = 0;
    for (int i = 0; i < 270; i++) begin
      na += int'(a_busy);
      nb += int'(b_busy);
      nv += int'(a_v);
      if (i < 250)
        step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             16'($urandom), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             (i < 150) ? 1'($urandom_range(0, 1)) : 1'b0);
      else idle();
    end
    chk("clr_a_busy_cycles", 32'(na), 32'd256);
    chk("clr_b_busy_cycles", 32'(nb), 32'd200);
    chk("clr_a_no_valid", 32'(nv), 32'd0);
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'h00, 1'b0);
    chk("clr_rd00_valid", 32'(a_v), 32'h1);
    chk("clr_rd00_data", 32'(a_data), 32'h0);
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'hFF, 1'b0);
    chk("clr_rdff_data", 32'(a_data), 32'h0);
    idle();
    idle();

    // Basic write then read, both latencies.
    step(1'b1, 8'h10, 16'hBEEF, 2'b11, 1'b0, 8'h0, 1'b0);
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'h10, 1'b0);
    chk("beef_a_valid", 32'(a_v), 32'h1);
    chk("beef_a_data", 32'(a_data), 32'hBEEF);
    chk("beef_b_early", 32'(b_v), 32'h0);
    idle();
    chk("beef_b_valid", 32'(b_v), 32'h1);
    chk("beef_b_data", 32'(b_data), 32'hBEEF);
    chk("beef_a_drop", 32'(a_v), 32'h0);

    // Byte masks.
    step(1'b1, 8'h05, 16'h1234, 2'b11, 1'b0, 8'h0, 1'b0);
    step(1'b1, 8'h05, 16'hABCD, 2'b10, 1'b0, 8'h0, 1'b0);
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'h05, 1'b0);
    chk("mask10_a_data", 32'(a_data), 32'hAB34);
    step(1'b1, 8'h05, 16'hFFFF, 2'b00, 1'b0, 8'h0, 1'b0);
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'h05, 1'b0);
    chk("mask00_a_data", 32'(a_data), 32'hAB34);
    idle();

    // Write-first bypass and in-flight isolation.
    step(1'b1, 8'h07, 16'h1111, 2'b11, 1'b0, 8'h0, 1'b0);
    step(1'b1, 8'h07, 16'h5555, 2'b11, 1'b1, 8'h07, 1'b0);
    chk("wf_a_data", 32'(a_data), 32'h5555);
    step(1'b1, 8'h07, 16'h9999, 2'b11, 1'b0, 8'h0, 1'b0);
    chk("wf_b_data", 32'(b_data), 32'h5555);
    idle();

    // Out-of-range on the 200-deep instance; in range on the other.
    step(1'b1, 8'd250, 16'h1234, 2'b11, 1'b1, 8'd250, 1'b0);
    chk("oob_b_err", 32'(b_err), 32'h1);
    chk("oob_a_err", 32'(a_err), 32'h0);
    chk("oob_a_data", 32'(a_data), 32'h1234);
    idle();
    chk("oob_b_err_once", 32'(b_err), 32'h0);
    chk("oob_b_valid", 32'(b_v), 32'h1);
    chk("oob_b_data", 32'(b_data), 32'h0);
    idle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           16'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 299) == 0));
    end
    idle();
    na = 0;
    while ((a_busy || b_busy) && na < 300) begin
      idle();
      na++;
    end
    chk("rand_drain_idle", 32'(a_busy | b_busy), 32'h0);

    // Reset in the middle of a clear.
    step(1'b1, 8'd150, 16'h7777, 2'b11, 1'b0, 8'h0, 1'b0);
    step(1'b1, 8'd99, 16'h4242, 2'b11, 1'b0, 8'h0, 1'b1);
    repeat (100) idle();
    chk("mid_busy", 32'(a_busy), 32'h1);
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'h3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_busy", 32'(a_busy), 32'h0);
    chk("mid_rst_a_valid", 32'(a_v), 32'h0);
    chk("mid_rst_b_busy", 32'(b_busy), 32'h0);
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    chk("post_rst_busy", 32'(a_busy), 32'h0);
    for (int i = 0; i < 160; i++)
      step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'd99, 1'b0);
    chk("post_rst_mem99", 32'(a_data), 32'h0);
    step(1'b0, 8'h0, 16'h0, 2'b00, 1'b1, 8'd150, 1'b0);
    chk("post_rst_mem150", 32'(a_data), 32'h7777);
    idle();
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
